instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Sequential reader for the 8-bit-wide, combinationally-read instruction memory of the neural-network controller. On a start command it walks the program counter from a start address to a last address inclusive, wrapping at the memory depth. It buffers fetched bytes in a small prefetch FIFO and presents them to the instruction decoder over a valid/ready handshake. It sits between the instruction RAM (address/enable/data port) and the decoder.

## Interface
- `MEM_DEPTH`, 128: number of instruction words; PC wraps from `MEM_DEPTH-1` to 0.
- `FIFO_DEPTH`, 4: prefetch FIFO entries, power of two, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a fetch run; sampled only in IDLE.
- `start_addr` input 8: first address of the run, sampled with `start`.
- `last_addr` input 8: final address of the run (inclusive), sampled with `start`.
- `abort` input 1: flush FIFO and return to IDLE.
- `ram_address` output 8: address to instruction RAM.
- `ram_enable` output 1: RAM read enable; high only in cycles where `ram_data` is captured.
- `ram_data` input 8: RAM read data, valid combinationally in the same cycle as `ram_address`/`ram_enable`.
- `instr` output 8: FIFO head instruction byte.
- `instr_valid` output 1: `instr` holds a valid byte.
- `instr_ready` input 1: decoder accepts `instr` this cycle.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last byte of a run is accepted.

## Operation
- States:
  - IDLE: `start`=1 loads PC←`start_addr`, latches `last_addr` → FETCH.
  - FETCH: issues reads.
  - DRAIN: all addresses issued, waits until the FIFO is empty.
  - DONE: pulses `done` for one cycle → IDLE.
- FETCH, fetch condition: fetch this cycle iff FIFO count < `FIFO_DEPTH`, or a pop happens this cycle (`instr_valid & instr_ready`).
- FETCH, when fetching:
  - `ram_enable`=1 and `ram_address`=PC.
  - `ram_data` is pushed at the clock edge.
  - If PC == latched last → DRAIN; else PC←(PC==`MEM_DEPTH-1`) ? 0 : PC+1.
- FETCH, when not fetching: `ram_enable`=0 and `ram_address` holds PC.
- Run length = ((last − start) mod `MEM_DEPTH`) + 1. `start_addr`==`last_addr` fetches exactly one byte. `start_addr` > `last_addr` wraps through 0.
- Address range: inputs ≥ `MEM_DEPTH` are reduced mod `MEM_DEPTH` on load (low bits for power-of-two depth).
- FIFO: pop on `instr_valid & instr_ready`. Simultaneous push and pop with count==`FIFO_DEPTH` is legal and leaves count unchanged. No byte is ever dropped or duplicated.
- `instr_valid` = (count ≠ 0). `instr` is stable while `instr_valid` is high and `instr_ready` is low.
- `abort`:
  - Valid in any state; highest priority over `start`, fetch and pop.
  - Next cycle: FIFO empty, `instr_valid`=0, `ram_enable`=0, state IDLE, no `done` pulse.
- `start` outside IDLE is ignored.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, PC=0, count=0.
- Output values in reset: `ram_address`=0, `ram_enable`=0, `instr`=0, `instr_valid`=0, `busy`=0, `done`=0.
- Latency, with `start` sampled at edge E0:
  - first `ram_enable` in cycle E0→E1, byte captured at E1;
  - `instr_valid`=1 after E1.
- Throughput: one byte per cycle sustained when `instr_ready`=1.
- `done`: high for the single cycle following the edge at which the FIFO became empty in DRAIN; `busy` falls with the transition to IDLE one edge later.
- `ram_enable` and `ram_address` are registered-free combinational decodes of state, PC and FIFO count. They never glitch high outside FETCH.
- Reset mid-run discards all state immediately. No `done` pulse.

## Test plan
- RAM[0..3]=2,2,3,3; `start` with start=0, last=3, `instr_ready`=1 → `instr` 2,2,3,3 on four consecutive valid cycles beginning one cycle after the first capture; `done` pulses once; `ram_enable` is high for exactly 4 cycles.
- Backpressure: `instr_ready`=0 over a 10-byte run → exactly 4 (`FIFO_DEPTH`) fetches, then `ram_enable`=0 with `instr` stable. Raise `instr_ready` → remaining 6 bytes in order, no loss.
- Wrap: `MEM_DEPTH`=128, start=126, last=1 → `ram_address` sequence 126,127,0,1; four bytes delivered; `done` pulses.
- Single word and full-FIFO simultaneity:
  - start=last=5 → exactly one fetch and one `done`.
  - Toggling `instr_ready` with the FIFO full → push and pop occur in the same cycle, count stays 4.
- Abort and reset mid-run:
  - `abort` with 2 bytes buffered and fetch pending → next cycle `instr_valid`=0, `busy`=0, no `done`.
  - A new `start` then runs cleanly.
  - `rst_n` low mid-fetch → all outputs 0 asynchronously.
- `start` asserted in FETCH/DRAIN is ignored: run length and `start_addr` are unchanged, verified by address trace.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: walks PC from start to last (inclusive, wrapping
// at MEM_DEPTH) and streams bytes through a small prefetch FIFO to the decoder.

module instr_fetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [CW-1:0] o_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;

  // Storage carries no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + AW'(1);
      if (i_pop)  r_rp <= r_rp + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout = r_mem[r_rp];
  assign o_cnt  = r_cnt;
endmodule

module instr_fetch_unit #(
  parameter int MEM_DEPTH  = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] start_addr,
  input  logic [7:0] last_addr,
  input  logic       abort,
  output logic [7:0] ram_address,
  output logic       ram_enable,
  input  logic [7:0] ram_data,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic       busy,
  output logic       done
);
  localparam int            CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);
  localparam logic [7:0]    PC_MAX = 8'(MEM_DEPTH - 1);
  localparam logic [31:0]   MD     = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t        r_state, w_nxt;
  logic [7:0]    r_pc, r_last;
  logic [7:0]    w_start_m, w_last_m;
  logic [7:0]    w_head;
  logic [CW-1:0] w_cnt;
  logic          w_pop, w_fetch, w_load, w_at_last;

  assign w_start_m = 8'({24'b0, start_addr} % MD);
  assign w_last_m  = 8'({24'b0, last_addr} % MD);

  assign instr_valid = (w_cnt != '0);
  assign instr       = instr_valid ? w_head : '0;

  // Abort outranks everything: it suppresses the pop, the fetch and the start.
  assign w_pop     = instr_valid & instr_ready & ~abort;
  assign w_fetch   = (r_state == S_FETCH) & ~abort & ((w_cnt != FULL) | w_pop);
  assign w_load    = (r_state == S_IDLE) & start & ~abort;
  assign w_at_last = (r_pc == r_last);

  assign ram_enable  = w_fetch;
  assign ram_address = r_pc;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

  instr_fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_push  (w_fetch),
    .i_din   (ram_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_nxt = S_FETCH;
        S_FETCH: if (w_fetch && w_at_last) w_nxt = S_DRAIN;
        // No pushes happen here, so the FIFO empties exactly when its last entry pops.
        S_DRAIN: if ((w_cnt == '0) || ((w_cnt == CW'(1)) && w_pop)) w_nxt = S_DONE;
        S_DONE:  w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_last <= '0;
    end else if (w_load) begin
      r_pc   <= w_start_m;
      r_last <= w_last_m;
    end else if (w_fetch && !w_at_last) begin
      r_pc   <= (r_pc == PC_MAX) ? 8'd0 : r_pc + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-based reference model is checked
// every cycle, with literal expectations on the directed scenarios.

module tb_instr_fetch_unit;
  localparam int MD = 128;
  localparam int FD = 4;

  logic       clk, rst_n, start, abort, instr_ready;
  logic [7:0] start_addr, last_addr, ram_address, ram_data, instr;
  logic       ram_enable, instr_valid, busy, done;

  logic [7:0] ram [MD];
  assign ram_data = ram[ram_address[6:0]];

  instr_fetch_unit #(.MEM_DEPTH(MD), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .last_addr   (last_addr),
    .abort       (abort),
    .ram_address (ram_address),
    .ram_enable  (ram_enable),
    .ram_data    (ram_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is "bytes still to fetch" plus a queue of buffered bytes.
  logic [7:0] mq [$];
  bit         m_run, m_done;
  int         m_pc, m_rem;
  bit         e_valid, e_pop, e_fetch;

  int         mon_addr [$];
  int         mon_bytes [$];
  int         mon_en, mon_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_run = 0; m_done = 0; m_pc = 0; m_rem = 0;
      chk("rst_instr", instr, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_en", ram_enable, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end else begin
      e_valid = (mq.size() != 0);
      e_pop   = e_valid && instr_ready && !abort;
      e_fetch = m_run && (m_rem > 0) && !abort && (mq.size() < FD || e_pop);
      chk("valid", instr_valid, int'(e_valid));
      if (e_valid) chk("instr", instr, int'(mq[0]));
      chk("ram_en", ram_enable, int'(e_fetch));
      if (e_fetch) chk("ram_addr", ram_address, m_pc);
      chk("busy", busy, int'(m_run || m_done));
      chk("done", done, int'(m_done));

      if (ram_enable) begin mon_addr.push_back(int'(ram_address)); mon_en++; end
      if (instr_valid && instr_ready && !abort) mon_bytes.push_back(int'(instr));
      if (done) mon_done++;

      if (abort) begin
        mq.delete();
        m_run = 0; m_done = 0; m_rem = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1;
          m_pc  = int'(start_addr) % MD;
          m_rem = ((int'(last_addr) % MD - int'(start_addr) % MD + MD) % MD) + 1;
        end
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (e_fetch) begin
          mq.push_back(ram[m_pc]);
          m_rem--;
          if (m_rem > 0) m_pc = (m_pc + 1) % MD;
        end
        if (m_rem == 0 && mq.size() == 0) begin m_run = 0; m_done = 1; end
      end
    end
  end

  task automatic cyc1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    mon_addr.delete();
    mon_bytes.delete();
    mon_en = 0;
    mon_done = 0;
  endtask

  // rmode: 1 = always ready, 2 = random ready. junk: drive spurious starts mid-run.
  task automatic do_run(input int s, input int l, input int rmode, input bit junk, input bit rnd_abort);
    int k;
    start_addr = 8'(s); last_addr = 8'(l); start = 1'b1;
    instr_ready = (rmode == 1) ? 1'b1 : 1'($urandom);
    cyc1;
    start = 1'b0;
    k = 0;
    while (busy && k < 3000) begin
      instr_ready = (rmode == 1) ? 1'b1 : 1'($urandom);
      abort = rnd_abort && ($urandom_range(0, 59) == 0);
      if (junk) begin
        start = 1'($urandom); start_addr = 8'($urandom); last_addr = 8'($urandom);
      end
      cyc1;
      k++;
    end
    start = 1'b0; abort = 1'b0;
    if (k >= 3000) chk("run_timeout", 1, 0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 3000) begin cyc1; k++; end
    if (k >= 3000) chk(name, 1, 0);
  endtask

  int hold;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
    start_addr = '0; last_addr = '0;
    clr_mon();
    for (int i = 0; i < MD; i++) ram[i] = 8'($urandom);
    ram[0] = 8'd2; ram[1] = 8'd2; ram[2] = 8'd3; ram[3] = 8'd3;
    repeat (3) cyc1;
    rst_n = 1'b1;
    cyc1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", instr_valid, 0);

    // Directed 4-byte run.
    clr_mon();
    do_run(0, 3, 1, 0, 0);
    chk("t1_nbytes", mon_bytes.size(), 4);
    if (mon_bytes.size() == 4) begin
      chk("t1_b0", mon_bytes[0], 2); chk("t1_b1", mon_bytes[1], 2);
      chk("t1_b2", mon_bytes[2], 3); chk("t1_b3", mon_bytes[3], 3);
    end
    chk("t1_en_cycles", mon_en, 4);
    chk("t1_done", mon_done, 1);

    // Backpressure over a 10-byte run.
    clr_mon();
    start_addr = 8'd10; last_addr = 8'd19; start = 1'b1; instr_ready = 1'b0;
    cyc1;
    start = 1'b0;
    repeat (12) cyc1;
    chk("bp_fetches", mon_en, FD);
    chk("bp_en_low", ram_enable, 0);
    hold = int'(instr);
    repeat (2) cyc1;
    chk("bp_stable", instr, hold);
    chk("bp_head", instr, int'(ram[10]));
    instr_ready = 1'b1;
    wait_idle("bp_timeout");
    chk("bp_nbytes", mon_bytes.size(), 10);
    for (int i = 0; i < mon_bytes.size() && i < 10; i++) chk("bp_byte", mon_bytes[i], int'(ram[10 + i]));
    chk("bp_total_en", mon_en, 10);
    chk("bp_done", mon_done, 1);

    // Wrap through address 0.
    clr_mon();
    do_run(126, 1, 1, 0, 0);
    chk("wrap_n", mon_addr.size(), 4);
    if (mon_addr.size() == 4) begin
      chk("wrap_a0", mon_addr[0], 126); chk("wrap_a1", mon_addr[1], 127);
      chk("wrap_a2", mon_addr[2], 0);   chk("wrap_a3", mon_addr[3], 1);
    end
    chk("wrap_bytes", mon_bytes.size(), 4);
    chk("wrap_done", mon_done, 1);

    // Single word.
    clr_mon();
    do_run(5, 5, 2, 0, 0);
    chk("one_en", mon_en, 1);
    chk("one_done", mon_done, 1);

    // Full FIFO: push and pop in the same cycle keeps it full.
    clr_mon();
    start_addr = 8'd60; last_addr = 8'd79; start = 1'b1; instr_ready = 1'b0;
    cyc1;
    start = 1'b0;
    repeat (6) cyc1;
    for (int i = 0; i < 4; i++) begin
      instr_ready = 1'b1; #1;
      chk("full_en_pop", ram_enable, 1);
      cyc1;
      instr_ready = 1'b0; #1;
      chk("full_en_hold", ram_enable, 0);
      cyc1;
    end
    instr_ready = 1'b1;
    wait_idle("full_timeout");
    chk("full_nbytes", mon_bytes.size(), 20);

    // Abort with two bytes buffered and a fetch pending.
    clr_mon();
    start_addr = 8'd20; last_addr = 8'd39; start = 1'b1; instr_ready = 1'b0;
    cyc1;
    start = 1'b0;
    repeat (2) cyc1;
    chk("ab_pre_en", ram_enable, 1);
    abort = 1'b1;
    cyc1;
    abort = 1'b0;
    chk("ab_valid", instr_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_en", ram_enable, 0);
    cyc1;
    chk("ab_nodone", mon_done, 0);
    clr_mon();
    do_run(30, 33, 2, 0, 0);
    chk("ab_rerun_n", mon_bytes.size(), 4);
    for (int i = 0; i < mon_bytes.size() && i < 4; i++) chk("ab_rerun_b", mon_bytes[i], int'(ram[30 + i]));

    // Start during FETCH/DRAIN/DONE is ignored.
    clr_mon();
    do_run(40, 44, 2, 1, 0);
    chk("ign_n", mon_addr.size(), 5);
    for (int i = 0; i < mon_addr.size() && i < 5; i++) chk("ign_addr", mon_addr[i], 40 + i);
    chk("ign_done", mon_done, 1);

    // Reset mid-fetch.
    clr_mon();
    start_addr = 8'd50; last_addr = 8'd70; start = 1'b1; instr_ready = 1'b0;
    cyc1;
    start = 1'b0;
    repeat (2) cyc1;
    #1 rst_n = 1'b0;
    #1;
    chk("mr_en", ram_enable, 0);
    chk("mr_addr", ram_address, 0);
    chk("mr_valid", instr_valid, 0);
    chk("mr_instr", instr, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    cyc1;
    rst_n = 1'b1;
    cyc1;
    chk("mr_nodone", mon_done, 0);

    // Randomized runs, including out-of-range addresses and sporadic aborts.
    for (int r = 0; r < 10; r++) do_run(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2, 0, 1);
    repeat (3) cyc1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
